// File: rtl/sdram_apb_csr.sv
// rtl/sdram_apb_csr.sv - APB4 completer for the SDRAM controller CSRs
//
// Registers: CTRL 0x0, TIME 0x4, TREF 0x8, STATUS 0xC (read-only).
// Every accepted CSR write toggles cfg_req_o and holds the transfer with
// PREADY=0 until the HCLK side returns the toggle on cfg_ack_i, or until
// ACK_TIMEOUT cycles pass (error completion, new value kept).
// A power-up delay counter gates init_start_o, a single-cycle pulse issued
// once CTRL.EN is set; clearing EN re-arms it.
//
// Ports:
//   PRESETn, PCLK        async active-low reset, rising-edge clock
//   PSEL..PWDATA         APB4 request (PPROT ignored)
//   PRDATA/PREADY/PSLVERR APB4 response, all registered
//   csr_ctrl_o/time/tref register contents for the core
//   cfg_req_o/cfg_ack_i  toggle handshake towards the HCLK domain
//   init_start_o         start SDRAM init sequence
//   init_done_i          init complete from HCLK domain (2FF-synced)
module sdram_apb_csr #(
    parameter int          PADDR_SIZE   = 4,
    parameter int          PDATA_SIZE   = 32,
    parameter int          INIT_DLY_CNT = 2500,
    parameter logic [31:0] TIME_RST     = 32'h0000_0000,
    parameter logic [31:0] TREF_RST     = 32'h0000_0000,
    parameter int          ACK_TIMEOUT  = 16
) (
    input  logic                    PRESETn,
    input  logic                    PCLK,
    input  logic                    PSEL,
    input  logic                    PENABLE,
    input  logic [PADDR_SIZE-1:0]   PADDR,
    input  logic                    PWRITE,
    input  logic [PDATA_SIZE/8-1:0] PSTRB,
    input  logic [2:0]              PPROT,
    input  logic [PDATA_SIZE-1:0]   PWDATA,
    output logic [PDATA_SIZE-1:0]   PRDATA,
    output logic                    PREADY,
    output logic                    PSLVERR,
    output logic [31:0]             csr_ctrl_o,
    output logic [31:0]             csr_time_o,
    output logic [31:0]             csr_tref_o,
    output logic                    cfg_req_o,
    input  logic                    cfg_ack_i,
    output logic                    init_start_o,
    input  logic                    init_done_i
);

    localparam logic [31:0] CTRL_MASK = 32'h00FF_1FFF;
    localparam int DW = (INIT_DLY_CNT > 1) ? $clog2(INIT_DLY_CNT) : 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, ACCESS, WAIT_ACK} state_t;

    state_t        state;
    logic [31:0]   ctrl_q, time_q, tref_q;
    logic [1:0]    ack_sync, done_sync;
    logic [DW-1:0] dly_cnt;
    logic [TW-1:0] tmo_cnt;
    logic          started;
    logic          dly_done;
    logic          addr_err, is_status;
    logic [31:0]   rd_mux;
    logic          unused;

    assign unused    = ^PPROT;
    assign dly_done  = (dly_cnt == DW'(INIT_DLY_CNT - 1));
    assign addr_err  = (PADDR[1:0] != 2'b00);
    assign is_status = (PADDR[3:2] == 2'd3);

    assign csr_ctrl_o = ctrl_q;
    assign csr_time_o = time_q;
    assign csr_tref_o = tref_q;

    function automatic logic [31:0] merge(input logic [31:0] old,
                                          input logic [31:0] wd,
                                          input logic [3:0]  strb);
        logic [31:0] res;
        res = old;
        for (int i = 0; i < 4; i++) begin
            if (strb[i]) res[8*i +: 8] = wd[8*i +: 8];
        end
        return res;
    endfunction

    always_comb begin
        rd_mux = 32'h0;
        case (PADDR[3:2])
            2'd0:    rd_mux = ctrl_q;
            2'd1:    rd_mux = time_q;
            2'd2:    rd_mux = tref_q;
            default: rd_mux = {29'b0, (state != IDLE), dly_done, done_sync[1]};
        endcase
    end

    // Cross-domain inputs; only the second stage is used.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            ack_sync  <= 2'b00;
            done_sync <= 2'b00;
        end else begin
            ack_sync  <= {ack_sync[0], cfg_ack_i};
            done_sync <= {done_sync[0], init_done_i};
        end
    end

    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            state     <= IDLE;
            PRDATA    <= '0;
            PREADY    <= 1'b1;
            PSLVERR   <= 1'b0;
            ctrl_q    <= 32'h0;
            time_q    <= TIME_RST;
            tref_q    <= TREF_RST;
            cfg_req_o <= 1'b0;
            tmo_cnt   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    PRDATA  <= '0;
                    PREADY  <= 1'b1;
                    PSLVERR <= 1'b0;
                    // Decode happens on the setup edge so the response is
                    // already registered in the first access cycle.
                    if (PSEL && !PENABLE) begin
                        state <= ACCESS;
                        if (addr_err || (PWRITE && is_status)) begin
                            PSLVERR <= 1'b1;
                        end else if (!PWRITE) begin
                            PRDATA <= rd_mux;
                        end else if (|PSTRB) begin
                            case (PADDR[3:2])
                                2'd0:    ctrl_q <= merge(ctrl_q, PWDATA, PSTRB) & CTRL_MASK;
                                2'd1:    time_q <= merge(time_q, PWDATA, PSTRB);
                                default: tref_q <= merge(tref_q, PWDATA, PSTRB);
                            endcase
                            cfg_req_o <= ~cfg_req_o;
                            PREADY    <= 1'b0;
                            tmo_cnt   <= '0;
                            state     <= WAIT_ACK;
                        end
                    end
                end
                ACCESS: begin
                    state   <= IDLE;
                    PRDATA  <= '0;
                    PREADY  <= 1'b1;
                    PSLVERR <= 1'b0;
                end
                WAIT_ACK: begin
                    if (!PSEL) begin
                        // Master abandoned the transfer; the register write stays.
                        state  <= IDLE;
                        PREADY <= 1'b1;
                    end else if (ack_sync[1] == cfg_req_o) begin
                        PREADY <= 1'b1;
                        state  <= ACCESS;
                    end else if (tmo_cnt == TW'(ACK_TIMEOUT - 1)) begin
                        PREADY  <= 1'b1;
                        PSLVERR <= 1'b1;
                        state   <= ACCESS;
                    end else begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Power-up delay and init start; started follows EN so that an
    // EN 0->1 sequence re-runs the init.
    always_ff @(posedge PCLK or negedge PRESETn) begin
        if (!PRESETn) begin
            dly_cnt      <= '0;
            started      <= 1'b0;
            init_start_o <= 1'b0;
        end else begin
            if (!dly_done) dly_cnt <= dly_cnt + 1'b1;
            init_start_o <= 1'b0;
            if (!ctrl_q[0]) begin
                started <= 1'b0;
            end else if (dly_done && !started) begin
                init_start_o <= 1'b1;
                started      <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_sdram_apb_csr.sv
// tb/tb_sdram_apb_csr.sv - directed self-checking bench for sdram_apb_csr
module tb_sdram_apb_csr;

    localparam logic [31:0] TIME_RST = 32'h1234_5678;
    localparam logic [31:0] TREF_RST = 32'h0000_0040;

    logic        PCLK = 1'b0;
    logic        PRESETn = 1'b0;
    logic        PSEL = 1'b0;
    logic        PENABLE = 1'b0;
    logic [3:0]  PADDR = 4'h0;
    logic        PWRITE = 1'b0;
    logic [3:0]  PSTRB = 4'h0;
    logic [2:0]  PPROT = 3'b000;
    logic [31:0] PWDATA = 32'h0;
    logic [31:0] PRDATA;
    logic        PREADY;
    logic        PSLVERR;
    logic [31:0] csr_ctrl_o, csr_time_o, csr_tref_o;
    logic        cfg_req_o;
    logic        cfg_ack_i = 1'b0;
    logic        init_start_o;
    logic        init_done_i = 1'b0;

    int n_checks = 0;
    int n_pass = 0;
    int toggles = 0;
    int pulses = 0;
    int first_pulse_edge = 0;
    int edge_cnt = 0;
    logic req_prev = 1'b0;

    sdram_apb_csr #(
        .PADDR_SIZE(4), .PDATA_SIZE(32), .INIT_DLY_CNT(100),
        .TIME_RST(TIME_RST), .TREF_RST(TREF_RST), .ACK_TIMEOUT(16)
    ) dut (
        .PRESETn(PRESETn), .PCLK(PCLK), .PSEL(PSEL), .PENABLE(PENABLE),
        .PADDR(PADDR), .PWRITE(PWRITE), .PSTRB(PSTRB), .PPROT(PPROT),
        .PWDATA(PWDATA), .PRDATA(PRDATA), .PREADY(PREADY), .PSLVERR(PSLVERR),
        .csr_ctrl_o(csr_ctrl_o), .csr_time_o(csr_time_o), .csr_tref_o(csr_tref_o),
        .cfg_req_o(cfg_req_o), .cfg_ack_i(cfg_ack_i),
        .init_start_o(init_start_o), .init_done_i(init_done_i)
    );

    always #5 PCLK = ~PCLK;

    always @(posedge PCLK) begin
        if (PRESETn) edge_cnt = edge_cnt + 1;
        else         edge_cnt = 0;
    end

    always @(negedge PCLK) begin
        if (cfg_req_o != req_prev) toggles = toggles + 1;
        req_prev = cfg_req_o;
        if (init_start_o) begin
            pulses = pulses + 1;
            if (pulses == 1) first_pulse_edge = edge_cnt;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, obs, exp);
    endtask

    // One APB transfer. The HCLK side is modelled by returning the toggle in
    // the ack_delay-th wait cycle (0 = never).
    task automatic apb_xfer(input logic wr, input logic [3:0] addr, input logic [31:0] wdata,
                            input logic [3:0] strb, input int ack_delay,
                            output logic [31:0] rdata, output logic err, output int lowcnt);
        @(posedge PCLK); #1;
        PSEL = 1'b1; PENABLE = 1'b0; PADDR = addr; PWRITE = wr; PWDATA = wdata; PSTRB = strb;
        @(posedge PCLK); #1;
        PENABLE = 1'b1;
        lowcnt = 0;
        while (!PREADY && lowcnt < 200) begin
            lowcnt++;
            if (lowcnt == ack_delay) cfg_ack_i = cfg_req_o;
            @(posedge PCLK); #1;
        end
        rdata = PRDATA;
        err   = PSLVERR;
        @(posedge PCLK); #1;
        PSEL = 1'b0; PENABLE = 1'b0; PWRITE = 1'b0;
    endtask

    task automatic do_reset();
        PRESETn = 1'b0; cfg_ack_i = 1'b0; init_done_i = 1'b0;
        PSEL = 1'b0; PENABLE = 1'b0;
        repeat (3) @(posedge PCLK);
        #1 PRESETn = 1'b1;
        pulses = 0;
    endtask

    logic [31:0] rd;
    logic        er;
    int          lc;
    int          t0;

    initial begin
        do_reset();

        // T1: reset state and zero-wait read of TIME
        check("rst_pready", 32'(PREADY), 32'd1);
        check("rst_pslverr", 32'(PSLVERR), 32'd0);
        check("rst_prdata", PRDATA, 32'h0);
        check("rst_req", 32'(cfg_req_o), 32'd0);
        check("rst_ctrl", csr_ctrl_o, 32'h0);
        check("rst_tref", csr_tref_o, TREF_RST);
        apb_xfer(1'b0, 4'h4, 32'h0, 4'h0, 0, rd, er, lc);
        check("t1_rdata", rd, TIME_RST);
        check("t1_wait", 32'(lc), 32'd0);
        check("t1_err", 32'(er), 32'd0);

        // T2: TREF write, ack returned in the 5th wait cycle
        t0 = toggles;
        apb_xfer(1'b1, 4'h8, 32'h0000_0186, 4'hF, 5, rd, er, lc);
        check("t2_wait", 32'(lc), 32'd7);
        check("t2_err", 32'(er), 32'd0);
        check("t2_toggles", 32'(toggles - t0), 32'd1);
        apb_xfer(1'b0, 4'h8, 32'h0, 4'h0, 0, rd, er, lc);
        check("t2_rdback", rd, 32'h0000_0186);
        check("t2_tref_o", csr_tref_o, 32'h0000_0186);

        // T3: byte-strobed CTRL write, masked bits dropped
        t0 = toggles;
        apb_xfer(1'b1, 4'h0, 32'hAABB_CCDD, 4'b0010, 1, rd, er, lc);
        check("t3_wait", 32'(lc), 32'd3);
        check("t3_toggles", 32'(toggles - t0), 32'd1);
        apb_xfer(1'b0, 4'h0, 32'h0, 4'h0, 0, rd, er, lc);
        check("t3_rdback", rd, 32'h0000_0C00);
        check("t3_ctrl_o", csr_ctrl_o, 32'h0000_0C00);

        // T4: write to STATUS and misaligned read are zero-wait errors
        t0 = toggles;
        apb_xfer(1'b1, 4'hC, 32'hFFFF_FFFF, 4'hF, 0, rd, er, lc);
        check("t4_st_err", 32'(er), 32'd1);
        check("t4_st_wait", 32'(lc), 32'd0);
        apb_xfer(1'b0, 4'h2, 32'h0, 4'h0, 0, rd, er, lc);
        check("t4_mis_err", 32'(er), 32'd1);
        check("t4_mis_rdata", rd, 32'h0);
        check("t4_toggles", 32'(toggles - t0), 32'd0);
        check("t4_time_o", csr_time_o, TIME_RST);

        // PSTRB=0 write: OKAY, no update, no toggle
        t0 = toggles;
        apb_xfer(1'b1, 4'h8, 32'h5555_5555, 4'h0, 0, rd, er, lc);
        check("s0_err", 32'(er), 32'd0);
        check("s0_wait", 32'(lc), 32'd0);
        check("s0_toggles", 32'(toggles - t0), 32'd0);
        check("s0_tref_o", csr_tref_o, 32'h0000_0186);

        // T5: ack never returned -> timeout error, value kept
        apb_xfer(1'b1, 4'h4, 32'hDEAD_BEEF, 4'hF, 0, rd, er, lc);
        check("t5_wait", 32'(lc), 32'd16);
        check("t5_err", 32'(er), 32'd1);
        apb_xfer(1'b0, 4'h4, 32'h0, 4'h0, 0, rd, er, lc);
        check("t5_rdback", rd, 32'hDEAD_BEEF);
        apb_xfer(1'b0, 4'hC, 32'h0, 4'h0, 0, rd, er, lc);
        check("t5_busy", 32'(rd[2]), 32'd0);

        // T6: power-up delay and init start from a fresh reset
        do_reset();
        while (edge_cnt < 9) begin @(posedge PCLK); #1; end
        apb_xfer(1'b1, 4'h0, 32'h0000_0001, 4'h1, 2, rd, er, lc);
        check("t6_en_err", 32'(er), 32'd0);
        apb_xfer(1'b0, 4'hC, 32'h0, 4'h0, 0, rd, er, lc);
        check("t6_status_early", rd, 32'h0);
        check("t6_no_pulse_yet", 32'(pulses), 32'd0);
        while (edge_cnt < 115) begin @(posedge PCLK); #1; end
        check("t6_pulses", 32'(pulses), 32'd1);
        check("t6_pulse_edge", 32'(first_pulse_edge), 32'd100);
        init_done_i = 1'b1;
        apb_xfer(1'b0, 4'hC, 32'h0, 4'h0, 0, rd, er, lc);
        check("t6_status_sync", rd, 32'h2);
        apb_xfer(1'b0, 4'hC, 32'h0, 4'h0, 0, rd, er, lc);
        check("t6_status_done", rd, 32'h3);
        apb_xfer(1'b1, 4'h0, 32'h0000_0000, 4'h1, 2, rd, er, lc);
        apb_xfer(1'b1, 4'h0, 32'h0000_0001, 4'h1, 2, rd, er, lc);
        repeat (5) @(posedge PCLK);
        #1;
        check("t6_repulse", 32'(pulses), 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
